uart_rx_buffer_ctrl: RTL

Receive-side controller placed between the UART receiver core and the host interface. It captures each received frame when the receiver signals valid, queues the frame together with its parity and stop error flags in a FIFO, and presents frames to the host over a valid/ready handshake. It also applies an error-drop policy and keeps the overrun and error-count status.

---
 rtl/uart_rx_buffer_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/uart_rx_buffer_ctrl.sv
// Receive-side frame buffer: edge-detects rx_valid, queues data plus error flags
// in a first-word-fall-through FIFO, and tracks overrun and error statistics.
module uart_rx_buffer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_parity_error,
  input  logic                  rx_stop_error,
  input  logic                  drop_on_error,
  input  logic                  flush,
  input  logic                  status_clr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_parity_error,
  output logic                  m_stop_error,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  output logic [7:0]            err_cnt
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr_reg;
  logic [ADDR_WIDTH-1:0]  rd_ptr_reg;
  logic [ADDR_WIDTH:0]    count_reg;
  logic                   rx_valid_d_reg;
  logic                   overrun_reg;
  logic [7:0]             err_cnt_reg;

  logic rx_event;
  logic rx_err;
  logic err_event;
  logic push_req;
  logic pop;
  logic push_ok;
  logic pop_ok;
  logic ovr_event;

  assign full    = (count_reg == COUNT_FULL);
  assign empty   = (count_reg == '0);
  assign m_valid = ~empty;
  assign count   = count_reg;
  assign overrun = overrun_reg;
  assign err_cnt = err_cnt_reg;

  assign rx_event  = rx_valid & ~rx_valid_d_reg;
  assign rx_err    = rx_parity_error | rx_stop_error;
  assign err_event = rx_event & rx_err;
  assign push_req  = rx_event & ~(drop_on_error & rx_err);
  assign pop       = m_valid & m_ready;
  // Flush overrides the whole FIFO datapath, including overrun detection.
  assign push_ok   = push_req & (~full | pop) & ~flush;
  assign pop_ok    = pop & ~flush;
  assign ovr_event = push_req & full & ~pop & ~flush;

  assign {m_parity_error, m_stop_error, m_data} = mem[rd_ptr_reg];

  // Storage entries are left unreset; only valid entries are ever presented.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == ADDR_WIDTH'(gi))) begin
          mem[gi] <= {rx_parity_error, rx_stop_error, rx_data};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A new event in the clear cycle wins over status_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid_d_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      rx_valid_d_reg <= rx_valid;
      if (ovr_event)       overrun_reg <= 1'b1;
      else if (status_clr) overrun_reg <= 1'b0;
      if (err_event) begin
        if (status_clr)                err_cnt_reg <= 8'd1;
        else if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      end else if (status_clr) begin
        err_cnt_reg <= '0;
      end
    end
  end

endmodule
